// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, fixed WIDTH+1 latency.
// Define MULT_SIGNED_EN to compile in two's-complement support selected by is_signed.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;

`ifdef MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  // The magnitude of the most negative value still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (sgn && v[WIDTH-1]) ? -sv : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return -sv;
  endfunction

  assign a_mag      = magnitude(A, is_signed);
  assign b_mag      = magnitude(B, is_signed);
  assign neg_in     = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign prod_final = neg ? negate(acc_sum) : acc_sum;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag            = A;
  assign b_mag            = B;
  assign prod_final       = acc_sum;
`endif

  assign accept  = start && (state != RUN);
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
`ifdef MULT_SIGNED_EN
        neg    <= neg_in;
`endif
      end else if (state == RUN) begin
        cnt    <= cnt + 1'b1;
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        // Result register only changes on the edge that enters DONE.
        if (cnt == CNT_LAST) product <= prod_final;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=16) against an arithmetic reference model.
module tb_seq_multiplier;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [2*W-1:0] product;

  int n_vec = 0;
  int n_err = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .A(a), .B(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    longint r;
    bit sm;
    sm = s;
`ifndef MULT_SIGNED_EN
    sm = 1'b0;
`endif
    if (sm) r = longint'($signed(x)) * longint'($signed(y));
    else    r = longint'(x) * longint'(y);
    return r[2*W-1:0];
  endfunction

  // Launch one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output logic [2*W-1:0] p, output int edges, output int busy_cnt,
                          output bit held);
    logic [2*W-1:0] pre;
    @(negedge clk);
    pre = product;
    start = 1'b1; a = x; b = y; is_signed = s;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
    edges = 1; busy_cnt = 0; held = 1'b1;
    while (!done && edges < 60) begin
      if (busy) busy_cnt++;
      if (product !== pre) held = 1'b0;
      @(negedge clk);
      edges++;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (product !== '0) begin n_err++; $display("FAIL reset_product: got %h want 0", product); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p; int e, bc; bit h;
    run_mult(16'd3, 16'd5, 1'b0, p, e, bc, h);
    n_vec++; if (p !== 32'h0000000F) begin n_err++; $display("FAIL basic_product: got %h want 0000000f", p); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", e, W + 1); end
    n_vec++; if (bc !== W) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL basic_product_held: got %b want 1", h); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    n_vec++; if (product !== 32'h0000000F) begin n_err++; $display("FAIL basic_product_hold_idle: got %h want 0000000f", product); end
  endtask

  task automatic test_corners();
    logic [2*W-1:0] p; int e, bc; bit h;
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, p, e, bc, h);
    n_vec++; if (p !== 32'hFFFE0001) begin n_err++; $display("FAIL max_product: got %h want fffe0001", p); end
    run_mult(16'h0000, 16'h1234, 1'b0, p, e, bc, h);
    n_vec++; if (p !== '0) begin n_err++; $display("FAIL zero_product: got %h want 0", p); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL zero_latency: got %0d want %0d", e, W + 1); end
    run_mult(16'hFFFF, 16'h0003, 1'b1, p, e, bc, h);
    n_vec++; if (p !== ref_mul(16'hFFFF, 16'h0003, 1'b1)) begin
      n_err++; $display("FAIL signed_neg1x3: got %h want %h", p, ref_mul(16'hFFFF, 16'h0003, 1'b1));
    end
    run_mult(16'h8000, 16'h8000, 1'b1, p, e, bc, h);
    n_vec++; if (p !== 32'h40000000) begin n_err++; $display("FAIL signed_minxmin: got %h want 40000000", p); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL signed_latency: got %0d want %0d", e, W + 1); end
    run_mult(16'h8000, 16'h8000, 1'b0, p, e, bc, h);
    n_vec++; if (p !== 32'h40000000) begin n_err++; $display("FAIL unsigned_8000sq: got %h want 40000000", p); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] p, exp; int e, bc; bit h;
    logic [W-1:0] x, y; logic s;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom); y = W'($urandom); s = 1'($urandom_range(0, 1));
      if (i == 0) x = 16'h8000;
      if (i == 1) y = 16'h7FFF;
      exp = ref_mul(x, y, s);
      run_mult(x, y, s, p, e, bc, h);
      n_vec++; if (p !== exp) begin
        n_err++; $display("FAIL random_product[%0d]: %h*%h s=%b got %h want %h", i, x, y, s, p, exp);
      end
      n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, e, W + 1); end
    end
  endtask

  task automatic test_ignore_start();
    int e, extra;
    @(negedge clk);
    start = 1'b1; a = 16'd3; b = 16'd5; is_signed = 1'b0;
    @(negedge clk);
    e = 1;
    while (!done && e < 60) begin
      if (e == 5) begin start = 1'b1; a = 16'd9; b = 16'd9; end
      else start = 1'b0;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    n_vec++; if (product !== 32'h0000000F) begin n_err++; $display("FAIL ignore_product: got %h want 0000000f", product); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", e, W + 1); end
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int e, e2;
    @(negedge clk);
    start = 1'b1; a = 16'd3; b = 16'd5; is_signed = 1'b0;
    @(negedge clk);
    a = 16'd2; b = 16'd7;
    e = 1;
    while (!done && e < 60) begin @(negedge clk); e++; end
    n_vec++; if (product !== 32'd15) begin n_err++; $display("FAIL b2b_first_product: got %0d want 15", product); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", e, W + 1); end
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble: got busy=%b want 1", busy); end
    e2 = 1;
    while (!done && e2 < 60) begin @(negedge clk); e2++; end
    n_vec++; if (e2 !== W + 1) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", e2, W + 1); end
    n_vec++; if (product !== 32'd14) begin n_err++; $display("FAIL b2b_second_product: got %0d want 14", product); end
  endtask

  task automatic test_reset_midrun();
    int e, seen;
    logic [2*W-1:0] p; int bc; bit h;
    @(negedge clk);
    start = 1'b1; a = 16'd7; b = 16'd9; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    e = 1;
    while (e < 8) begin @(negedge clk); e++; end
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    n_vec++; if (product !== '0) begin n_err++; $display("FAIL midrst_product: got %h want 0", product); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin @(negedge clk); if (done || busy) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_activity: got %0d want 0", seen); end
    run_mult(16'd3, 16'd5, 1'b0, p, e, bc, h);
    n_vec++; if (p !== 32'd15) begin n_err++; $display("FAIL postrst_product: got %0d want 15", p); end
    n_vec++; if (e !== W + 1) begin n_err++; $display("FAIL postrst_latency: got %0d want %0d", e, W + 1); end
    n_vec++; if (bc !== W) begin n_err++; $display("FAIL postrst_busy_cycles: got %0d want %0d", bc, W); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
